color_sequencer: RTL
====================

# color_sequencer

Frame-synchronous controller that selects the text color for the initials renderer. It sits between the VGA sync generator and `Iniciales`. It watches the pixel coordinates and drives the eight one-hot color-select inputs (`Black` … `White`). The selection advances automatically every N frames or on a push-button, and changes only at a frame boundary so a frame never shows two colors.

## Interface
- `FRAMES_PER_COLOR`, default 60: frames shown per color in auto mode (1..255).
- `DEBOUNCE_CYCLES`, default 500000: stable cycles required on `btn_next` (used only with the debounce macro).
- `clk`  in  1  system/pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pix_x`  in  10  current pixel column from the sync generator (0..799).
- `pix_y`  in  10  current pixel row (0..524).
- `auto_en`  in  1  1 = auto cycling, 0 = manual only.
- `btn_next`  in  1  raw level; each rising edge requests advancing one color.
- `color_onehot`  out  8  one-hot select; bit0 = Black, bit1 = Blue, bit2 = Green, bit3 = Cyan, bit4 = Red, bit5 = Magenta, bit6 = Yellow, bit7 = White.
- `color_code`  out  3  binary index of the active color; same order as the bits.
- `frame_tick`  out  1  one-cycle pulse on each detected frame start.

## Operation
- Frame start is the first cycle where `pix_x==0 && pix_y==0` after a cycle where it was false. Register `at_origin_q` and detect its rising edge.
  - `at_origin_q` resets to 1, so being at the origin during reset does not produce a tick.
- Button path: rising edge of the (optionally debounced) `btn_next` sets `pending`.
  - `pending` saturates; any number of presses within one frame gives one advance.
- Frame counter `fcnt` (8 bits):
  - Increments on each `frame_tick` while `auto_en=1`.
  - Held at 0 while `auto_en=0`.
- FSM states:
  - WAIT: idle until a frame start.
  - ADVANCE: one cycle, updates color.
  - WAIT→ADVANCE on `frame_tick` when either `pending=1` or (`auto_en=1` and `fcnt==FRAMES_PER_COLOR-1`).
  - Otherwise WAIT stays WAIT.
  - ADVANCE→WAIT always.
- ADVANCE actions:
  - `color_code <= color_code+1`, wrapping 7→0.
  - `fcnt <= 0`; `pending <= 0`.
  - A button edge arriving in the same cycle as ADVANCE is kept: `pending` stays 1.
- Simultaneous button request and auto terminal count at one frame start: advance exactly once.
- `color_onehot` is always the decode of `color_code`. It is registered and never all-zero or multi-hot.
- `pix_x`/`pix_y` outside the visible range are ignored, except for origin detection.
- `reset` at any time: return to the reset state immediately; any pending request is lost.

## Timing
- Reset values:
  - `color_code=0` and `color_onehot=8'h01` (Black).
  - `frame_tick=0`, `fcnt=0`, `pending=0`, FSM=WAIT.
- `frame_tick` is asserted in the cycle after the origin is first seen.
- `color_code`/`color_onehot` update 2 cycles after the origin is first seen. This lands within the first two pixel clocks of the frame, during blanking.
- Auto mode: color period is exactly `FRAMES_PER_COLOR` frame ticks.
- Manual mode: latency from button edge to color change is up to one frame plus 2 cycles, plus `DEBOUNCE_CYCLES` when debounce is enabled.

## Configuration
- `COLSEQ_DEBOUNCE_EN` defined:
  - `btn_next` passes through a 2-flop synchronizer and a debouncer.
  - The filtered level changes only after `DEBOUNCE_CYCLES` consecutive cycles of a stable new value.
- `COLSEQ_DEBOUNCE_EN` undefined:
  - Only the 2-flop synchronizer is used; no counter logic is synthesized.
  - The edge detect acts on the synchronized raw level.

## Structure
- Package `colseq_pkg`:
  - Color index constants `COL_BLACK`=0 … `COL_WHITE`=7.
  - FSM state encoding.
  - Function `color_decode(code) -> onehot[7:0]`.
- Sub-module `colseq_debounce`:
  - Contains the synchronizer, the counter sized by `$clog2(DEBOUNCE_CYCLES+1)`, and the stable-level register.
  - Instantiated only under `COLSEQ_DEBOUNCE_EN`.

## Test plan
- Reset, then release at `pix_x=0`, `pix_y=0` → no `frame_tick` until the coordinates leave and return to the origin; outputs stay `color_onehot=8'h01`.
- `auto_en=1`, `FRAMES_PER_COLOR=2`, sweep 800×525 frames → `color_code` goes 0,0,1,1,2 … and wraps 7→0 after 16 frames; each change occurs 2 cycles after the origin.
- `auto_en=0`, three `btn_next` pulses mid-frame → exactly one advance (0→1) at the next frame start; none at the following frame.
- `auto_en=1` with a button press in the same frame as the terminal count → single advance; `fcnt` restarts at 0.
- Assert `reset` mid-frame with `pending=1` and `color_code=5` → outputs return immediately to Black/0 and no advance happens at the next frame.
- With `COLSEQ_DEBOUNCE_EN` and `DEBOUNCE_CYCLES=16`: a 10-cycle glitch on `btn_next` gives no advance; a 20-cycle press gives one advance.

Source files
------------

// File: rtl/colseq_pkg.sv
// Shared definitions for the color sequencer: color indices, FSM encoding and
// the index-to-one-hot decode used to drive the renderer's select inputs.
package colseq_pkg;

    localparam logic [2:0] COL_BLACK   = 3'd0;
    localparam logic [2:0] COL_BLUE    = 3'd1;
    localparam logic [2:0] COL_GREEN   = 3'd2;
    localparam logic [2:0] COL_CYAN    = 3'd3;
    localparam logic [2:0] COL_RED     = 3'd4;
    localparam logic [2:0] COL_MAGENTA = 3'd5;
    localparam logic [2:0] COL_YELLOW  = 3'd6;
    localparam logic [2:0] COL_WHITE   = 3'd7;

    typedef enum logic {
        StWait    = 1'b0,
        StAdvance = 1'b1
    } colseq_state_e;

    function automatic logic [7:0] color_decode(input logic [2:0] code);
        logic [7:0] onehot;
        onehot       = '0;
        onehot[code] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/colseq_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a counter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive stable cycles.
module colseq_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // Any return to the accepted level restarts the stability count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign btn_level = level_q;

endmodule

// File: rtl/color_sequencer.sv
// Frame-synchronous text color selector; advances on auto count or button and
// only at a frame start. Define COLSEQ_DEBOUNCE_EN to debounce btn_next.
module color_sequencer
    import colseq_pkg::*;
#(
    parameter int unsigned FRAMES_PER_COLOR = 60,
    parameter int unsigned DEBOUNCE_CYCLES  = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       auto_en,
    input  logic       btn_next,
    output logic [7:0] color_onehot,
    output logic [2:0] color_code,
    output logic       frame_tick
);

    if (FRAMES_PER_COLOR < 1 || FRAMES_PER_COLOR > 255 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("color_sequencer: parameter out of range");
    end

    localparam logic [7:0] FCNT_LAST = 8'(FRAMES_PER_COLOR - 1);

    logic btn_level;

`ifdef COLSEQ_DEBOUNCE_EN
    colseq_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_next),
        .btn_level(btn_level)
    );
`else
    logic [1:0] btn_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_sync_q <= '0;
        end else begin
            btn_sync_q <= {btn_sync_q[0], btn_next};
        end
    end

    assign btn_level = btn_sync_q[1];
`endif

    logic          btn_prev_q;
    logic          btn_rise;
    logic          at_origin;
    logic          at_origin_q;
    logic          frame_start;
    logic          advance_req;
    colseq_state_e state_q, state_d;
    logic [2:0]    color_q, color_d;
    logic [7:0]    onehot_q;
    logic [7:0]    fcnt_q, fcnt_d;
    logic          pending_q, pending_d;

    assign btn_rise    = btn_level & ~btn_prev_q;
    assign at_origin   = (pix_x == 10'd0) && (pix_y == 10'd0);
    assign frame_start = at_origin & ~at_origin_q;
    // A press seen on the frame-start cycle itself is honoured by this frame.
    assign advance_req = pending_q | btn_rise | (auto_en && (fcnt_q == FCNT_LAST));

    always_comb begin
        state_d   = state_q;
        color_d   = color_q;
        fcnt_d    = fcnt_q;
        pending_d = pending_q | btn_rise;
        unique case (state_q)
            StWait: begin
                if (frame_start) begin
                    if (auto_en) begin
                        fcnt_d = fcnt_q + 8'd1;
                    end
                    if (advance_req) begin
                        state_d = StAdvance;
                    end
                end
            end
            StAdvance: begin
                color_d   = color_q + 3'd1;
                fcnt_d    = '0;
                pending_d = btn_rise;
                state_d   = StWait;
            end
            default: state_d = StWait;
        endcase
        if (!auto_en) begin
            fcnt_d = '0;
        end
    end

    // at_origin_q starts high so sitting at the origin out of reset is not a frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_prev_q  <= 1'b0;
            at_origin_q <= 1'b1;
            frame_tick  <= 1'b0;
            state_q     <= StWait;
            color_q     <= COL_BLACK;
            onehot_q    <= color_decode(COL_BLACK);
            fcnt_q      <= '0;
            pending_q   <= 1'b0;
        end else begin
            btn_prev_q  <= btn_level;
            at_origin_q <= at_origin;
            frame_tick  <= frame_start;
            state_q     <= state_d;
            color_q     <= color_d;
            onehot_q    <= color_decode(color_d);
            fcnt_q      <= fcnt_d;
            pending_q   <= pending_d;
        end
    end

    assign color_code   = color_q;
    assign color_onehot = onehot_q;

endmodule
